// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the controller/execute side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic              instr_ack;
  logic              branch;
  logic              zero;
  logic              negative;
  logic              fault;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc, instr_valid, fault,
    input  imem_rvalid, imem_rdata, instr_ack, branch, zero, negative
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc, instr_valid, fault,
    output imem_rvalid, imem_rdata, instr_ack, branch, zero, negative
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction and resolves
// the next PC (sequential or SB-type branch) when execute acknowledges the held instruction.
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StHold, StFault} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [31:0]       r_instr, w_instr_d;
  logic              r_instr_valid, w_instr_valid_d;
  logic [7:0]        r_wait_cnt, w_wait_cnt_d;

  logic              w_cond, w_taken;
  logic [ADDR_W-1:0] w_imm_b, w_next_pc;

  always_comb begin
    w_cond = 1'b0;
    case (r_instr[14:12])
      3'b000:  w_cond = bus.zero;
      3'b001:  w_cond = ~bus.zero;
      3'b100:  w_cond = bus.negative;
      3'b101:  w_cond = ~bus.negative;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = bus.branch & w_cond;
  assign w_imm_b   = {{(ADDR_W-13){r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
  // Modulo-2^ADDR_W add: wrap-around is intentionally silent.
  assign w_next_pc = w_taken ? (r_pc + w_imm_b) : (r_pc + ADDR_W'(4));

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_instr_d       = r_instr;
    w_instr_valid_d = r_instr_valid;
    w_wait_cnt_d    = r_wait_cnt;
    unique case (r_state)
      StIdle: w_state_d = StFetch;
      StFetch: begin
        w_wait_cnt_d = '0;
        w_state_d    = StWait;
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          w_instr_d       = bus.imem_rdata;
          w_instr_valid_d = 1'b1;
          w_wait_cnt_d    = '0;
          w_state_d       = StHold;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 8'd1;
          if (w_wait_cnt_d == MaxWaitC) w_state_d = StFault;
        end
      end
      StHold: begin
        if (bus.instr_ack) begin
          w_instr_valid_d = 1'b0;
          // A misaligned target keeps the old PC and faults.
          if (w_next_pc[1:0] != 2'b00) begin
            w_state_d = StFault;
          end else begin
            w_pc_d    = w_next_pc;
            w_state_d = StFetch;
          end
        end
      end
      StFault: w_instr_valid_d = 1'b0;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0013;
      r_instr_valid <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_instr       <= w_instr_d;
      r_instr_valid <= w_instr_valid_d;
      r_wait_cnt    <= w_wait_cnt_d;
    end
  end

  assign bus.imem_req    = (r_state == StFetch);
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.pc          = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.fault       = (r_state == StFault);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decode controller in the single-cycle RISC-V core.
- Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/rvalid handshake.
- Presents the instruction and its opcode to the controller until the execute side acknowledges it.
- Picks the next PC: sequential, or SB-type branch resolved from the controller's branch output plus ALU zero/negative flags.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
RESET_PC, 0, PC value loaded on reset
MAX_WAIT, 15, max cycles in WAIT without rvalid before fault (1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request, one-cycle pulse
imem_addr  output  ADDR_W  fetch address, equals pc
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
instr  output  32  held instruction
opcode  output  7  instr[6:0], to controller
pc  output  ADDR_W  address of held instruction
instr_valid  output  1  instr/opcode valid for execution
instr_ack  input  1  execute side finished with current instruction
branch  input  1  controller branch output for current instruction
zero  input  1  ALU zero flag
negative  input  1  ALU negative flag
fault  output  1  sticky fetch fault

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge: pc=RESET_PC, state=IDLE, imem_req=0, instr=32'h00000013 (NOP), instr_valid=0, fault=0, wait counter=0.
- States: IDLE, FETCH, WAIT, HOLD, FAULT.
- IDLE: one cycle after reset release, then FETCH.
- FETCH: imem_req=1 for exactly this cycle; imem_addr=pc. Next state WAIT. rvalid in FETCH is ignored.
- WAIT: imem_req=0.
  - On imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, counter cleared, next state HOLD.
  - Otherwise the counter increments. If it reaches MAX_WAIT without rvalid, next state FAULT.
  - Fetch latency is 2 cycles minimum: FETCH edge to instr_valid high.
- HOLD: instr, opcode and pc are stable; instr_valid=1. Without instr_ack, stay in HOLD indefinitely. On instr_ack=1, in the same edge:
  - instr_valid<=0.
  - pc<=next_pc.
  - Next state FETCH.
  - If next_pc[1:0]!=0, pc is not updated and next state is FAULT.
- next_pc:
  - taken = branch & cond(funct3=instr[14:12]).
  - cond: 000 BEQ = zero; 001 BNE = ~zero; 100 BLT = negative; 101 BGE = ~negative; other funct3 = 0.
  - imm_b = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} (13-bit to ADDR_W).
  - next_pc = taken ? pc+imm_b : pc+4. Arithmetic is modulo 2^ADDR_W: wrap-around is silent, not a fault.
- instr_ack outside HOLD is ignored. branch/zero/negative are sampled only on the HOLD-ack edge.
- FAULT: fault=1, instr_valid=0, imem_req=0. Exit only via reset.
- Reset mid-operation: returns to IDLE regardless of state. The memory side must not return rvalid for a request aborted by reset. An rvalid in IDLE/FETCH is ignored.
- imem_rdata is captured only on the WAIT-rvalid edge. Later rdata changes do not affect instr.

Test Plan:
- Reset release, memory returns rvalid 1 cycle after req with 32'h00500093 -> req at addr 0; instr_valid high 2 cycles after FETCH; opcode=7'h13; ack -> next req at addr 4.
- HOLD with branch=1, zero=1, instr=32'hFE000EE3 (BEQ, offset -4) at pc=8, ack -> next imem_addr=4. Same with zero=0 -> 12.
- BLT at pc=0x100, offset +16, negative=1 -> 0x110; BGE with negative=1 -> 0x104; branch=0 with any flags -> 0x104.
- rvalid withheld for MAX_WAIT cycles -> fault=1 and stays 1, no further imem_req; rst_n=0 for one edge -> fault=0, pc=RESET_PC, new req.
- instr_ack pulsed during WAIT -> ignored; instr_valid held for 10 cycles without ack -> instr/pc unchanged; pc=32'hFFFFFFFC sequential -> next addr 0, no fault.
- rst_n asserted during HOLD with ack simultaneously high -> reset wins: pc=RESET_PC, instr_valid=0, state IDLE.
